flag_cond_unit: RTL and testbench

Consumer end of the ALU flag interface. Holds the architectural NZCV status register, which the ALU's 4-bit flags output {N,Z,C,V} writes. Evaluates 4-bit condition codes against that register for the issue/branch logic. Tracks flag-setting ALU operations still in flight, so a condition is never evaluated against stale flags.

---
 rtl/flag_cond_unit_pkg.sv | 9 +
 rtl/flag_cond_unit_cond_eval.sv | 18 +
 rtl/flag_cond_unit.sv | 83 ++++++++
 tb/tb_flag_cond_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/flag_cond_unit_pkg.sv
// flag_cond_unit_pkg: shared condition-code, flag-index and FSM state types
package flag_cond_unit_pkg;
    typedef enum logic [3:0] {EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV} cond_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// cond_eval: combinational ARM condition-code test against an NZCV nibble
module cond_eval
    import flag_cond_unit_pkg::*;
(
    input  logic [3:0] flags_i,
    input  cond_e      cond_i,
    output logic       pass_o
);
    logic       n, z, c, v;
    logic [7:0] base;
    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];
    // Odd codes are the inverse of the even code below them; NV is the inverse of AL
    assign base   = {1'b1, ~z & (n == v), n == v, c & ~z, v, n, c, z};
    assign pass_o = base[cond_i[3:1]] ^ cond_i[0];
endmodule

// File: rtl/flag_cond_unit.sv
// flag_cond_unit: NZCV status register, in-flight flag-op tracking and
// condition evaluation that waits until no flag-setting op is outstanding.
module flag_cond_unit
    import flag_cond_unit_pkg::*;
#(
    parameter int         CNT_W     = 3,
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_set_flags,
    output logic             issue_ready,
    input  logic             alu_valid,
    input  logic             alu_set_flags,
    input  logic [3:0]       alu_flags,
    input  logic             req_valid,
    input  logic [3:0]       req_cond,
    output logic             req_ready,
    output logic             resp_valid,
    output logic             resp_pass,
    input  logic             resp_ready,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] inflight
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_e           state_q, state_d;
    cond_e            cond_q, cond_d, eval_cond;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       flags_d;
    logic             pass_q, pass_d, eval_pass, flag_wr, inc, dec;
    assign flag_wr = alu_valid & alu_set_flags;
    assign dec     = flag_wr & (cnt_q != '0);
    // A return frees a slot, so an issue at the limit is taken when it coincides with one
    assign inc     = issue_set_flags & (cnt_q != CNT_MAX | dec);
    assign cnt_d   = (inc & ~dec) ? cnt_q + 1'b1 : (dec & ~inc) ? cnt_q - 1'b1 : cnt_q;
    assign flags_d = flag_wr ? alu_flags : flags_q;
    assign eval_cond = (state_q == IDLE) ? cond_e'(req_cond) : cond_q;
    cond_eval u_cond_eval (
        .flags_i(flags_d),
        .cond_i (eval_cond),
        .pass_o (eval_pass)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cond_q  <= EQ;
            cnt_q   <= '0;
            flags_q <= RST_FLAGS;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            pass_q  <= pass_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cond_d  = cond_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: if (req_valid) begin
                cond_d  = cond_e'(req_cond);
                state_d = (cnt_d == '0) ? RESP : WAIT;
                pass_d  = (cnt_d == '0) ? eval_pass : pass_q;
            end
            WAIT: if (cnt_d == '0) begin
                state_d = RESP;
                pass_d  = eval_pass;
            end
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        req_ready   = state_q == IDLE;
        resp_valid  = state_q == RESP;
        resp_pass   = pass_q;
        issue_ready = cnt_q != CNT_MAX;
        inflight    = cnt_q;
    end
endmodule

// File: tb/tb_flag_cond_unit.sv
// tb_flag_cond_unit: directed vectors; expected pass bits are queued at request
// time and a monitor compares them whenever a response handshake occurs.
module tb_flag_cond_unit;
    logic       clk = 1'b0, rst = 1'b1;
    logic       issue_set_flags = 1'b0, alu_valid = 1'b0, alu_set_flags = 1'b0;
    logic       req_valid = 1'b0, resp_ready = 1'b1;
    logic [3:0] alu_flags = 4'h0, req_cond = 4'h0;
    logic       issue_ready, req_ready, resp_valid, resp_pass;
    logic [3:0] flags_q;
    logic [2:0] inflight;
    int         n_cmp = 0, n_err = 0;
    bit         exp_q[$];
    logic [15:0] pass_z, pass_nv;

    flag_cond_unit #(.CNT_W(3), .RST_FLAGS(4'b0000)) dut (
        .clk(clk), .rst(rst),
        .issue_set_flags(issue_set_flags), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_set_flags(alu_set_flags), .alu_flags(alu_flags),
        .req_valid(req_valid), .req_cond(req_cond), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_pass(resp_pass), .resp_ready(resp_ready),
        .flags_q(flags_q), .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got pass=%0b expected no response", resp_pass);
            end else begin
                check("resp_pass", 32'(resp_pass), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_wr(input logic [3:0] f);
        alu_valid = 1'b1; alu_set_flags = 1'b1; alu_flags = f;
        tick();
        alu_valid = 1'b0; alu_set_flags = 1'b0;
    endtask

    task automatic req(input logic [3:0] c, input bit e);
        exp_q.push_back(e);
        req_valid = 1'b1; req_cond = c;
        for (int i = 0; i < 50 && !req_ready; i++) tick();
        if (!req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_accept: got req_ready=0 expected 1 within 50 cycles");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        pass_z  = 16'h66A9;
        pass_nv = 16'h565A;
        tick();
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_pass", resp_pass, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_inflight", inflight, 0);
        check("rst_flags", flags_q, 4'b0000);
        rst = 1'b0;
        tick();
        // Full code sweep for Z-only and N,V flags
        alu_wr(4'b0100);
        check("flags_z", flags_q, 4'b0100);
        for (int c = 0; c < 16; c++) begin
            req(4'(c), pass_z[c]);
            drain();
        end
        alu_wr(4'b1001);
        check("flags_nv", flags_q, 4'b1001);
        for (int c = 0; c < 16; c++) begin
            req(4'(c), pass_nv[c]);
            drain();
        end
        // Flag write on the accepting edge must be seen by the evaluation
        alu_valid = 1'b1; alu_set_flags = 1'b1; alu_flags = 4'b0100;
        req(4'h0, 1'b1);
        alu_valid = 1'b0; alu_set_flags = 1'b0;
        drain();
        check("same_edge_flags", flags_q, 4'b0100);
        // Wait for two outstanding flag ops; result uses the last one
        issue_set_flags = 1'b1;
        tick();
        tick();
        issue_set_flags = 1'b0;
        check("wait_inflight2", inflight, 2);
        req(4'h1, 1'b1);
        check("wait_req_ready", req_ready, 0);
        check("wait_resp_valid", resp_valid, 0);
        alu_wr(4'b0100);
        check("wait_inflight1", inflight, 1);
        check("wait_still", resp_valid, 0);
        alu_wr(4'b0000);
        check("wait_done_valid", resp_valid, 1);
        drain();
        // Counter saturation
        issue_set_flags = 1'b1;
        repeat (7) tick();
        check("sat_inflight7", inflight, 7);
        check("sat_issue_ready", issue_ready, 0);
        tick();
        check("sat_8th_ignored", inflight, 7);
        alu_valid = 1'b1; alu_set_flags = 1'b1; alu_flags = 4'b0000;
        tick();
        check("sat_inc_dec", inflight, 7);
        issue_set_flags = 1'b0; alu_valid = 1'b0; alu_set_flags = 1'b0;
        repeat (7) alu_wr(4'b0000);
        check("sat_drained", inflight, 0);
        check("sat_issue_ready1", issue_ready, 1);
        alu_wr(4'b0000);
        check("dec_at_zero", inflight, 0);
        // Backpressure with flags changing underneath
        resp_ready = 1'b0;
        alu_wr(4'b0010);
        req(4'h2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            alu_wr(4'(i * 3));
            check("bp_pass", resp_pass, 1);
            check("bp_valid", resp_valid, 1);
            check("bp_req_ready", req_ready, 0);
        end
        check("bp_flags", flags_q, 4'b1100);
        resp_ready = 1'b1;
        drain();
        // Asynchronous reset while a response is held
        resp_ready = 1'b0;
        req(4'hE, 1'b1);
        issue_set_flags = 1'b1;
        tick();
        issue_set_flags = 1'b0;
        check("pre_rst_valid", resp_valid, 1);
        check("pre_rst_inflight", inflight, 1);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_resp_valid", resp_valid, 0);
        check("arst_flags", flags_q, 4'b0000);
        check("arst_inflight", inflight, 0);
        check("arst_req_ready", req_ready, 1);
        check("arst_issue_ready", issue_ready, 1);
        tick();
        rst = 1'b0;
        resp_ready = 1'b1;
        req(4'hF, 1'b0);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
